// File: rtl/dcache_assoc_if.sv
// Bundles the pipeline-side request bus and the memory-side bus of the data cache.
// The slave modport is the cache view; the master modport is its environment.
interface dcache_assoc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;
  logic                  flush_req;
  logic                  flush_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output req_valid, req_write, funct3, addr, wdata, flush_req, mem_rdata, mem_ack,
    input  rdata, stall, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata, flush_req, mem_rdata, mem_ack,
    output rdata, stall, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with one-word lines,
// round-robin replacement and a full dirty-line flush walk.
module dcache_assoc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2
) (
  input  logic           clk,
  input  logic           rst,
  dcache_assoc_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WSH   = $clog2(NUM_WAYS);
  localparam int WAY_W = (WSH > 0) ? WSH : 1;
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam int CNT_W = IDX_W + WSH;
  localparam int LAST  = NUM_SETS * NUM_WAYS - 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_done_q, flush_done_d;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [WAY_W-1:0]      rr_q    [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       lane;
  assign idx     = bus.addr[2 +: IDX_W];
  assign req_tag = bus.addr[ADDR_WIDTH-1 -: TAG_W];
  assign lane    = bus.addr[1:0];

  logic [NUM_WAYS-1:0] way_hit;
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_match
    assign way_hit[gi] = valid_q[idx][gi] && (tag_q[idx][gi] == req_tag);
  end

  logic [IDX_W-1:0] fl_set;
  logic [WAY_W-1:0] fl_way;
  assign fl_set = flush_cnt_q[CNT_W-1 -: IDX_W];
  if (WSH > 0) begin : g_fway
    assign fl_way = flush_cnt_q[WAY_W-1:0];
  end else begin : g_fway_one
    assign fl_way = '0;
  end

  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, vict_way, rr_inc;
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vict_way  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && way_hit[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        vict_way  = WAY_W'(w);
      end
    end
    if (!inv_found) vict_way = rr_q[idx];
  end
  assign rr_inc = (NUM_WAYS == 1) ? '0 : rr_q[idx] + 1'b1;

  logic [DATA_WIDTH-1:0] hit_data, load_val, store_val;
  logic [7:0]            sel_b;
  logic [15:0]           sel_h;
  assign hit_data = data_q[idx][hit_way];
  assign sel_b    = hit_data[{lane, 3'b000} +: 8];
  assign sel_h    = hit_data[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (bus.funct3)
      3'd0:    load_val = {{(DATA_WIDTH-8){sel_b[7]}}, sel_b};
      3'd1:    load_val = {{(DATA_WIDTH-16){sel_h[15]}}, sel_h};
      3'd4:    load_val = {{(DATA_WIDTH-8){1'b0}}, sel_b};
      3'd5:    load_val = {{(DATA_WIDTH-16){1'b0}}, sel_h};
      default: load_val = hit_data;
    endcase
    store_val = hit_data;
    case (bus.funct3[1:0])
      2'd0:    store_val[{lane, 3'b000} +: 8]     = bus.wdata[7:0];
      2'd1:    store_val[{lane[1], 4'b0000} +: 16] = bus.wdata[15:0];
      default: store_val = bus.wdata;
    endcase
  end

  logic store_en, refill_en, flush_clr, rr_adv, fl_adv;
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    flush_cnt_d   = flush_cnt_q;
    flush_done_d  = 1'b0;
    store_en      = 1'b0;
    refill_en     = 1'b0;
    flush_clr     = 1'b0;
    rr_adv        = 1'b0;
    fl_adv        = 1'b0;
    bus.rdata     = '0;
    bus.stall     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && hit) begin
          if (bus.req_write) store_en = 1'b1;
          else               bus.rdata = load_val;
        end
        if (bus.req_valid && !hit) begin
          bus.stall = 1'b1;
          victim_d  = vict_way;
          rr_adv    = 1'b1;
          state_d   = dirty_q[idx][vict_way] ? WB : REFILL;
        end else if (bus.flush_req) begin
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end
      end
      WB: begin
        bus.stall     = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {tag_q[idx][victim_q], idx, 2'b00};
        bus.mem_wdata = data_q[idx][victim_q];
        if (bus.mem_ack) state_d = REFILL;
      end
      REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
        if (bus.mem_ack) begin
          refill_en = 1'b1;
          state_d   = IDLE;
        end
      end
      FLUSH: begin
        bus.stall = 1'b1;
        if (dirty_q[fl_set][fl_way]) begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = {tag_q[fl_set][fl_way], fl_set, 2'b00};
          bus.mem_wdata = data_q[fl_set][fl_way];
          flush_clr     = bus.mem_ack;
          fl_adv        = bus.mem_ack;
        end else begin
          fl_adv = 1'b1;
        end
        if (fl_adv) begin
          if (flush_cnt_q == CNT_W'(LAST)) begin
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.flush_done = flush_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      flush_cnt_q  <= '0;
      flush_done_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_done_q <= flush_done_d;
      if (rr_adv)    rr_q[idx] <= rr_inc;
      if (store_en)  dirty_q[idx][hit_way] <= 1'b1;
      if (refill_en) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      if (flush_clr) dirty_q[fl_set][fl_way] <= 1'b0;
    end
  end

  // Tag and data payload carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (store_en) data_q[idx][hit_way] <= store_val;
    if (refill_en) begin
      data_q[idx][victim_q] <= bus.mem_rdata;
      tag_q[idx][victim_q]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (4 sets x 2 ways) with a 3-cycle-ack memory model.
module tb_dcache_assoc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_assoc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dcache_assoc #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SETS(4), .NUM_WAYS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] wb_addr[$];
  logic [31:0] wb_data[$];
  logic [31:0] rd_addr[$];
  int mcnt;

  // Memory answers each transaction on its third cycle with a one-cycle ack.
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_ack = 1'b0;
      mcnt = 0;
      mem[32'h300] = 32'h33333333;
    end else begin
      #2;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        mcnt = 0;
      end
      if (bus.mem_req === 1'b1 && !rst) begin
        mcnt++;
        if (mcnt == 3) begin
          mcnt = 0;
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wb_addr.push_back(bus.mem_addr);
            wb_data.push_back(bus.mem_wdata);
          end else begin
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
            rd_addr.push_back(bus.mem_addr);
          end
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int sc);
    bus.req_valid = 1'b1;
    bus.req_write = we;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    sc = 0;
    @(negedge clk);
    while (bus.stall !== 1'b0 && sc < 60) begin
      sc++;
      @(negedge clk);
    end
    rd = bus.rdata;
    $display("txn we=%0b f3=%0d addr=%h wdata=%h rdata=%h stall_cycles=%0d", we, f3, a, wd, rd, sc);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
  endtask

  task automatic run_flush(output int fc, output logic done);
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    fc = 0;
    done = 1'b0;
    while (!done && fc < 100) begin
      @(negedge clk);
      if (bus.flush_done === 1'b1) done = 1'b1;
      else fc++;
    end
    $display("txn flush cycles=%0d done=%0b", fc, done);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.funct3 = 3'd2;
    bus.addr = '0; bus.wdata = '0; bus.flush_req = 1'b0;
    #12;
    checks++;
    if ({bus.stall, bus.mem_req, bus.mem_we, bus.flush_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {bus.stall, bus.mem_req, bus.mem_we, bus.flush_done});
    end
    checks++;
    if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    checks++;
    if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
    checks++;
    if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int sc, rb, wbb;
    rb = rd_addr.size(); wbb = wb_addr.size();
    access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, rd, sc);
    checks++;
    if (sc != 4) begin errors++; $display("FAIL sw_miss_stall: got %0d expected 4", sc); end
    checks++;
    if (rd_addr.size() != rb + 1 || rd_addr[rb] !== 32'h100) begin
      errors++; $display("FAIL sw_refill_addr: got count %0d expected one read at 00000100", rd_addr.size() - rb);
    end
    access(1'b0, 3'd2, 32'h100, 32'h0, rd, sc);
    checks++;
    if (sc != 0 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_hit: got %h stall %0d expected deadbeef stall 0", rd, sc);
    end
    checks++;
    if (wb_addr.size() != wbb) begin errors++; $display("FAIL no_wb: got %0d write-backs expected 0", wb_addr.size() - wbb); end
  endtask

  task automatic test_subword();
    logic [31:0] rd;
    int sc;
    access(1'b0, 3'd0, 32'h103, 32'h0, rd, sc);
    checks++;
    if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb: got %h expected ffffffde", rd); end
    access(1'b0, 3'd4, 32'h103, 32'h0, rd, sc);
    checks++;
    if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu: got %h expected 000000de", rd); end
    access(1'b0, 3'd1, 32'h100, 32'h0, rd, sc);
    checks++;
    if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh: got %h expected ffffbeef", rd); end
    access(1'b0, 3'd5, 32'h102, 32'h0, rd, sc);
    checks++;
    if (rd !== 32'h0000DEAD || sc != 0) begin errors++; $display("FAIL lhu: got %h stall %0d expected 0000dead stall 0", rd, sc); end
  endtask

  task automatic test_evict();
    logic [31:0] rd;
    int sc, wbb;
    access(1'b1, 3'd2, 32'h200, 32'h22222222, rd, sc);
    checks++;
    if (sc != 4) begin errors++; $display("FAIL fill_way1_stall: got %0d expected 4", sc); end
    wbb = wb_addr.size();
    access(1'b0, 3'd2, 32'h300, 32'h0, rd, sc);
    checks++;
    if (sc != 7) begin errors++; $display("FAIL dirty_miss_stall: got %0d expected 7", sc); end
    checks++;
    if (wb_addr.size() != wbb + 1 || wb_addr[wbb] !== 32'h100 || wb_data[wbb] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL evict_wb: got count %0d expected one write-back 00000100=deadbeef", wb_addr.size() - wbb);
    end
    checks++;
    if (rd !== 32'h33333333 || rd_addr[rd_addr.size()-1] !== 32'h300) begin
      errors++; $display("FAIL evict_refill: got %h expected 33333333 from 00000300", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int sc, rb;
    rb = rd_addr.size();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.funct3 = 3'd2; bus.addr = 32'h10C;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10C) begin
      errors++; $display("FAIL refill_active: got req %b we %b addr %h expected 1 0 0000010c", bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_drops_req: got %b expected 0", bus.mem_req); end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rd_addr.size() != rb || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL abandoned_txn: got %0d reads req %b expected 0 reads req 0", rd_addr.size() - rb, bus.mem_req);
    end
    @(posedge clk);
    #1;
    access(1'b0, 3'd2, 32'h100, 32'h0, rd, sc);
    checks++;
    if (sc != 4 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL post_reset_miss: got %h stall %0d expected deadbeef stall 4", rd, sc);
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    logic done;
    int sc, fc, wbb;
    access(1'b1, 3'd2, 32'h104, 32'h01040104, rd, sc);
    access(1'b1, 3'd2, 32'h208, 32'h02080208, rd, sc);
    wbb = wb_addr.size();
    run_flush(fc, done);
    checks++;
    if (!done || fc != 12) begin errors++; $display("FAIL flush_cycles: got %0d done %b expected 12 done 1", fc, done); end
    @(negedge clk);
    checks++;
    if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_pulse: got %b expected 0", bus.flush_done); end
    checks++;
    if (wb_addr.size() != wbb + 2 || wb_addr[wbb] !== 32'h104 || wb_addr[wbb+1] !== 32'h208
        || wb_data[wbb] !== 32'h01040104 || wb_data[wbb+1] !== 32'h02080208) begin
      errors++; $display("FAIL flush_wbs: got count %0d expected 00000104 then 00000208", wb_addr.size() - wbb);
    end
    @(posedge clk);
    #1;
    access(1'b0, 3'd2, 32'h104, 32'h0, rd, sc);
    checks++;
    if (sc != 0 || rd !== 32'h01040104) begin errors++; $display("FAIL flush_keep_104: got %h stall %0d expected 01040104 stall 0", rd, sc); end
    access(1'b0, 3'd2, 32'h208, 32'h0, rd, sc);
    checks++;
    if (sc != 0 || rd !== 32'h02080208) begin errors++; $display("FAIL flush_keep_208: got %h stall %0d expected 02080208 stall 0", rd, sc); end
    wbb = wb_addr.size();
    run_flush(fc, done);
    checks++;
    if (!done || fc != 8 || wb_addr.size() != wbb) begin
      errors++; $display("FAIL clean_flush: got %0d cycles %0d wbs expected 8 cycles 0 wbs", fc, wb_addr.size() - wbb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd;
    logic done;
    int sc, fc, wbb;
    access(1'b1, 3'd2, 32'h100, 32'h11223344, rd, sc);
    access(1'b1, 3'd0, 32'h101, 32'h000000AA, rd, sc);
    checks++;
    if (sc != 0) begin errors++; $display("FAIL sb_hit_stall: got %0d expected 0", sc); end
    access(1'b0, 3'd2, 32'h100, 32'h0, rd, sc);
    checks++;
    if (rd !== 32'h1122AA44) begin errors++; $display("FAIL sb_merge: got %h expected 1122aa44", rd); end
    wbb = wb_addr.size();
    run_flush(fc, done);
    checks++;
    if (!done || wb_addr.size() != wbb + 1 || wb_addr[wbb] !== 32'h100 || wb_data[wbb] !== 32'h1122AA44) begin
      errors++; $display("FAIL sb_dirty: got %0d wbs done %b expected one 00000100=1122aa44", wb_addr.size() - wbb, done);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword();
    test_evict();
    test_reset_mid();
    test_flush();
    test_byte_merge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
